// File: rtl/qpp_pkg.sv
// Shared constants, types and per-size selectors for the QPP turbo-interleaver address stage.
// Selects between the two supported block sizes (K = 1056 and K = 6144).
package qpp_pkg;

   localparam int unsigned AW = 14;

   localparam int unsigned K_SMALL  = 1056;
   localparam int unsigned F1_SMALL = 17;
   localparam int unsigned F2_SMALL = 66;
   localparam int unsigned K_LARGE  = 6144;
   localparam int unsigned F1_LARGE = 263;
   localparam int unsigned F2_LARGE = 480;

   // Seeds of the recursion: g(0) = f1 + f2 and the constant increment of g is 2*f2.
   localparam int unsigned G0_SMALL = (F1_SMALL + F2_SMALL) % K_SMALL;
   localparam int unsigned DG_SMALL = 2 * F2_SMALL;
   localparam int unsigned G0_LARGE = (F1_LARGE + F2_LARGE) % K_LARGE;
   localparam int unsigned DG_LARGE = 2 * F2_LARGE;

   typedef logic [AW-1:0] word_t;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   function automatic word_t k_of(input logic k);
      return k ? word_t'(K_LARGE) : word_t'(K_SMALL);
   endfunction

   function automatic word_t g0_of(input logic k);
      return k ? word_t'(G0_LARGE) : word_t'(G0_SMALL);
   endfunction

   function automatic word_t dg_of(input logic k);
      return k ? word_t'(DG_LARGE) : word_t'(DG_SMALL);
   endfunction

endpackage

// File: rtl/qpp_addr_gen_if.sv
// Index-in / address-out bundle of the QPP address stage.
// With QPP_BYPASS_EN defined the bundle also carries the bypass select.
interface qpp_addr_gen_if;
   import qpp_pkg::*;

`ifdef QPP_BYPASS_EN
   logic  bypass;
`endif
   logic  k;
   logic  start;
   logic  idx_valid;
   word_t idx;
   logic  addr_valid;
   word_t addr;
   logic  addr_last;
   logic  done;
   logic  err;

   modport master (
`ifdef QPP_BYPASS_EN
      output bypass,
`endif
      output k, start, idx_valid, idx,
      input  addr_valid, addr, addr_last, done, err
   );

   modport slave (
`ifdef QPP_BYPASS_EN
      input  bypass,
`endif
      input  k, start, idx_valid, idx,
      output addr_valid, addr, addr_last, done, err
   );

endinterface

// File: rtl/qpp_mod_add.sv
// Combinational (a + b) mod m for operands already reduced below m.
// A single conditional subtract suffices because a + b < 2*m.
module qpp_mod_add
   import qpp_pkg::*;
(
   input  word_t a,
   input  word_t b,
   input  word_t m,
   output word_t sum
);

   logic [AW:0] raw;
   logic [AW:0] red;

   assign raw = {1'b0, a} + {1'b0, b};
   assign red = raw - {1'b0, m};
   assign sum = (raw >= {1'b0, m}) ? red[AW-1:0] : raw[AW-1:0];

endmodule

// File: rtl/qpp_addr_gen.sv
// QPP interleaver address stage: pi(i) = (f1*i + f2*i^2) mod K via add-only recursion.
// Optional identity-address bypass is compiled in with QPP_BYPASS_EN.
module qpp_addr_gen
   import qpp_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   qpp_addr_gen_if.slave  bus
);

   state_e state_q, state_d;
   logic   k_q, k_d;
   word_t  pi_q, pi_d;
   word_t  g_q, g_d;
   word_t  exp_q, exp_d;
   logic   err_q, err_d;
   word_t  addr_q, addr_d;
   logic   addr_valid_q, addr_valid_d;
   logic   addr_last_q, addr_last_d;

   word_t  ksel;
   word_t  pi_next;
   word_t  g_next;
   logic   bypass;
   logic   is_last;

   assign ksel    = k_of(k_q);
   assign is_last = (bus.idx == ksel - 1'b1);

`ifdef QPP_BYPASS_EN
   assign bypass = bus.bypass;
`else
   assign bypass = 1'b0;
`endif

   qpp_mod_add u_pi_add (
      .a   (pi_q),
      .b   (g_q),
      .m   (ksel),
      .sum (pi_next)
   );

   qpp_mod_add u_g_add (
      .a   (g_q),
      .b   (dg_of(k_q)),
      .m   (ksel),
      .sum (g_next)
   );

   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      pi_d         = pi_q;
      g_d          = g_q;
      exp_d        = exp_q;
      err_d        = err_q;
      addr_d       = addr_q;
      addr_valid_d = 1'b0;
      addr_last_d  = 1'b0;

      // A start pulse wins over any index offered in the same cycle.
      if (bus.start) begin
         k_d     = bus.k;
         pi_d    = '0;
         g_d     = g0_of(bus.k);
         exp_d   = '0;
         err_d   = 1'b0;
         state_d = StRun;
      end else begin
         unique case (state_q)
            StRun: begin
               if (bus.idx_valid) begin
                  if (bus.idx == exp_q) begin
                     addr_d       = bypass ? bus.idx : pi_q;
                     addr_valid_d = 1'b1;
                     addr_last_d  = is_last;
                     pi_d         = pi_next;
                     g_d          = g_next;
                     exp_d        = exp_q + 1'b1;
                     if (is_last) begin
                        state_d = StDone;
                     end
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            StIdle, StDone: begin
               // Indices are ignored; DONE absorbs the generator's repeated K-1.
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         k_q          <= 1'b0;
         pi_q         <= '0;
         g_q          <= '0;
         exp_q        <= '0;
         err_q        <= 1'b0;
         addr_q       <= '0;
         addr_valid_q <= 1'b0;
         addr_last_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         pi_q         <= pi_d;
         g_q          <= g_d;
         exp_q        <= exp_d;
         err_q        <= err_d;
         addr_q       <= addr_d;
         addr_valid_q <= addr_valid_d;
         addr_last_q  <= addr_last_d;
      end
   end

   assign bus.addr       = addr_q;
   assign bus.addr_valid = addr_valid_q;
   assign bus.addr_last  = addr_last_q;
   assign bus.done       = (state_q == StDone);
   assign bus.err        = err_q;

endmodule
